// File: rtl/dut_vector_engine.sv
// dut_vector_engine: applies stimulus vectors to a DUT and waits for a cycle count or a trigger.
// Ports: clock/reset_n; sfifo_*/cfifo_* pop stimulus/commands; rfifo_* push records; mosi/miso pins; busy.
module dut_vector_engine #(
  parameter int STF_WIDTH   = 24,
  parameter int RTF_WIDTH   = 24,
  parameter int CYCLE_RANGE = 5,
  parameter int CMD_WIDTH   = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [STF_WIDTH+CYCLE_RANGE:0] sfifo_data,
  input  logic                           sfifo_rdempty,
  output logic                           sfifo_rdreq,
  input  logic [CMD_WIDTH+STF_WIDTH-1:0] cfifo_data,
  input  logic                           cfifo_rdempty,
  output logic                           cfifo_rdreq,
  output logic [RTF_WIDTH+CYCLE_RANGE:0] rfifo_data,
  output logic                           rfifo_wrreq,
  input  logic                           rfifo_wrfull,
  output logic [STF_WIDTH-1:0]           mosi_data,
  input  logic [RTF_WIDTH-1:0]           miso_data,
  output logic                           busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WRITE
  } state_t;

  localparam logic [CMD_WIDTH-1:0] OP_MUX  = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] OP_MASK = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] OP_VAL  = CMD_WIDTH'(3);
  localparam logic [CYCLE_RANGE-1:0] ONE   = CYCLE_RANGE'(1);

  state_t state;
  state_t state_next;

  logic [CMD_WIDTH-1:0]   opcode;
  logic [STF_WIDTH-1:0]   operand;
  logic                   st_mode;
  logic [CYCLE_RANGE-1:0] st_cycles;
  logic [STF_WIDTH-1:0]   st_vector;

  logic [STF_WIDTH-1:0]   vector_reg;
  logic [STF_WIDTH-1:0]   mux_config;
  logic [RTF_WIDTH-1:0]   trig_mask;
  logic [RTF_WIDTH-1:0]   trig_value;
  logic                   mode_reg;
  logic [CYCLE_RANGE-1:0] cycles_reg;
  logic [CYCLE_RANGE-1:0] counter;
  logic [CYCLE_RANGE-1:0] count_next;
  logic [RTF_WIDTH+CYCLE_RANGE:0] record;

  logic trig_hit;
  logic at_limit;
  logic capture;
  logic en;
  logic clock_gated;

  assign opcode    = cfifo_data[CMD_WIDTH+STF_WIDTH-1:STF_WIDTH];
  assign operand   = cfifo_data[STF_WIDTH-1:0];
  assign st_mode   = sfifo_data[0];
  assign st_cycles = sfifo_data[CYCLE_RANGE:1];
  assign st_vector = sfifo_data[STF_WIDTH+CYCLE_RANGE:CYCLE_RANGE+1];

  // The counter value seen during a RUN cycle is 1-based.
  assign count_next = counter + ONE;
  assign trig_hit   = (miso_data & trig_mask) == (trig_value & trig_mask);
  assign at_limit   = count_next == cycles_reg;
  assign capture    = (state == RUN) && (at_limit || (mode_reg && trig_hit));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    cfifo_rdreq = 1'b0;
    sfifo_rdreq = 1'b0;
    rfifo_wrreq = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cfifo_rdempty) begin
          cfifo_rdreq = 1'b1;
        end else if (!sfifo_rdempty) begin
          sfifo_rdreq = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (capture) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!rfifo_wrfull) begin
          rfifo_wrreq = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vector_reg <= '0;
      mux_config <= '0;
      trig_mask  <= '0;
      trig_value <= '0;
      mode_reg   <= 1'b0;
      cycles_reg <= ONE;
      counter    <= '0;
      record     <= '0;
    end else begin
      if (cfifo_rdreq) begin
        case (opcode)
          OP_MUX:  mux_config <= operand;
          OP_MASK: trig_mask  <= operand[RTF_WIDTH-1:0];
          OP_VAL:  trig_value <= operand[RTF_WIDTH-1:0];
          default: ;
        endcase
      end
      if (sfifo_rdreq) begin
        vector_reg <= st_vector;
        mode_reg   <= st_mode;
        // Zero cycles behaves as one, so the counter cannot wrap.
        cycles_reg <= (st_cycles == '0) ? ONE : st_cycles;
        counter    <= '0;
      end
      if (state == RUN) begin
        counter <= count_next;
        if (capture) begin
          // A trigger match wins over reaching the limit.
          record <= {mode_reg & ~trig_hit, count_next, miso_data};
        end
      end
    end
  end

  // Loaded on the falling edge so the gated clock never glitches.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      en <= 1'b1;
    end else begin
      en <= !((state == WRITE) && rfifo_wrfull);
    end
  end

  assign clock_gated = clock & en;
  assign mosi_data   = (mux_config & {STF_WIDTH{clock_gated}})
                     | (vector_reg & ~mux_config);
  assign rfifo_data  = record;
  assign busy        = state != IDLE;

endmodule

// File: tb/tb_dut_vector_engine.sv
// tb_dut_vector_engine: random and directed stimulus for dut_vector_engine,
// checked every cycle against a table-driven behavioural model.
module tb_dut_vector_engine;

  localparam int SW = 24;
  localparam int RW = 24;
  localparam int CR = 5;
  localparam int CW = 8;
  localparam int NT = 6000;

  typedef struct {
    logic [23:0] vec;
    logic        mode;
    logic [4:0]  cyc;
    int          fk;
    logic [23:0] fval;
    bit          fill;
    logic [23:0] fillv;
    int          stall;
  } stim_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [SW+CR:0]   sfifo_data;
  logic             sfifo_rdempty;
  logic             sfifo_rdreq;
  logic [CW+SW-1:0] cfifo_data;
  logic             cfifo_rdempty;
  logic             cfifo_rdreq;
  logic [RW+CR:0]   rfifo_data;
  logic             rfifo_wrreq;
  logic             rfifo_wrfull;
  logic [SW-1:0]    mosi_data;
  logic [RW-1:0]    miso_data;
  logic             busy;

  dut_vector_engine #(
    .STF_WIDTH(SW), .RTF_WIDTH(RW), .CYCLE_RANGE(CR), .CMD_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .sfifo_data(sfifo_data), .sfifo_rdempty(sfifo_rdempty),
    .sfifo_rdreq(sfifo_rdreq),
    .cfifo_data(cfifo_data), .cfifo_rdempty(cfifo_rdempty),
    .cfifo_rdreq(cfifo_rdreq),
    .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq),
    .rfifo_wrfull(rfifo_wrfull),
    .mosi_data(mosi_data), .miso_data(miso_data), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;

  stim_t sq[$];
  logic [31:0] cq[$];
  logic [23:0] miso_tab[NT];
  bit wf_tab[NT];

  logic [23:0] m_mux, m_mask, m_val, m_vec;
  logic [29:0] m_rec;
  bit rec_pend;
  bit gate;
  int cap_at, wr_at, busy_until;
  int cyc;

  logic [29:0] got[$];
  int obs_s[$];
  int obs_c[$];
  int lowcnt;
  logic [23:0] mosi_ap;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic stim_t mk(logic [23:0] v, logic md, logic [4:0] c,
                               int fk, logic [23:0] fv, bit fl,
                               logic [23:0] flv, int st);
    stim_t s;
    s.vec = v; s.mode = md; s.cyc = c;
    s.fk = fk; s.fval = fv; s.fill = fl; s.fillv = flv; s.stall = st;
    return s;
  endfunction

  task automatic model_reset();
    m_mux = '0; m_mask = '0; m_val = '0; m_vec = '0; m_rec = '0;
    rec_pend = 0; gate = 1; cap_at = 0; wr_at = 0;
    busy_until = cyc - 1;
  endtask

  task automatic model_cmd();
    logic [31:0] c;
    c = cq[0];
    case (c[31:24])
      8'h01: m_mux = c[23:0];
      8'h02: m_mask = c[23:0];
      8'h03: m_val = c[23:0];
      default: ;
    endcase
  endtask

  // Looks ahead in the miso/full tables to decide the whole transaction.
  task automatic model_pop(int n);
    stim_t s;
    int eff, k;
    logic [23:0] m;
    logic to;
    s = sq[0];
    eff = (s.cyc == 0) ? 1 : int'(s.cyc);
    if (s.fill) for (int i = 1; i <= eff; i++) miso_tab[n+i] = s.fillv;
    if (s.fk > 0) miso_tab[n+s.fk] = s.fval;
    k = eff; m = miso_tab[n+eff]; to = s.mode;
    for (int i = 1; i <= eff; i++) begin
      if (s.mode && ((miso_tab[n+i] & m_mask) == (m_val & m_mask))) begin
        k = i; m = miso_tab[n+i]; to = 1'b0;
        break;
      end
    end
    m_rec = {to, 5'(k), m};
    cap_at = n + k;
    if (s.stall > 0) begin
      for (int i = 1; i <= s.stall; i++) wf_tab[cap_at+i] = 1;
      wf_tab[cap_at+s.stall+1] = 0;
    end
    wr_at = cap_at + 1;
    while (wf_tab[wr_at] && wr_at < NT - 1) wr_at++;
    busy_until = wr_at;
    rec_pend = 1;
    m_vec = s.vec;
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic step();
    bit idle, ec, es, inw, ew, ds, dc;
    logic [23:0] hi_exp;
    if (cyc >= NT - 70) begin
      chk("cycle_budget", cyc, NT - 70);
      n_fail++;
      $display("FAIL cycle_budget: ran out of table at cycle %0d", cyc);
      finish_run();
    end
    sfifo_rdempty = (sq.size() == 0);
    sfifo_data = (sq.size() > 0) ? {sq[0].vec, sq[0].cyc, sq[0].mode} : '0;
    cfifo_rdempty = (cq.size() == 0);
    cfifo_data = (cq.size() > 0) ? cq[0] : '0;
    miso_data = miso_tab[cyc];
    rfifo_wrfull = wf_tab[cyc];
    @(negedge clock);
    idle = cyc > busy_until;
    ec = reset_n && idle && (cq.size() > 0);
    es = reset_n && idle && !ec && (sq.size() > 0);
    inw = rec_pend && (cyc > cap_at);
    ew = inw && !rfifo_wrfull;
    ds = sfifo_rdreq;
    dc = cfifo_rdreq;
    chk("cfifo_rdreq", dc, ec);
    chk("sfifo_rdreq", ds, es);
    chk("rfifo_wrreq", rfifo_wrreq, ew);
    chk("busy", busy, !idle);
    chk("mosi_lo", mosi_data, m_vec & ~m_mux);
    if (ew) chk("rfifo_data", rfifo_data, m_rec);
    if (!reset_n) chk("rfifo_data_rst", rfifo_data, 0);
    if (rfifo_wrreq) got.push_back(rfifo_data);
    if (obs_s.size() > 0 && cyc == obs_s[$] + 1) mosi_ap = mosi_data;
    gate = !(inw && rfifo_wrfull);
    if (ec) model_cmd();
    else if (es) model_pop(cyc);
    if (ew) rec_pend = 0;
    @(posedge clock);
    #2;
    hi_exp = (m_vec & ~m_mux) | (gate ? m_mux : 24'h0);
    chk("mosi_hi", mosi_data, hi_exp);
    if (m_mux[0] && !mosi_data[0]) lowcnt++;
    if (ds) begin
      obs_s.push_back(cyc);
      if (sq.size() > 0) void'(sq.pop_front());
    end
    if (dc) begin
      obs_c.push_back(cyc);
      if (cq.size() > 0) void'(cq.pop_front());
    end
    cyc++;
  endtask

  task automatic drain(int max);
    int i;
    i = 0;
    while ((sq.size() > 0 || cq.size() > 0 || cyc <= busy_until) && i < max) begin
      step();
      i++;
    end
    if (i >= max) chk("drain_timeout", i, 0);
  endtask

  initial begin
    int n0;
    cyc = 0;
    lowcnt = 0;
    mosi_ap = '0;
    for (int i = 0; i < NT; i++) begin
      miso_tab[i] = 24'($urandom);
      wf_tab[i] = ($urandom_range(0, 3) == 0);
    end
    wf_tab[NT-1] = 0;
    model_reset();
    sfifo_rdempty = 1; sfifo_data = '0;
    cfifo_rdempty = 1; cfifo_data = '0;
    miso_data = '0; rfifo_wrfull = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mosi", mosi_data, 0);
    chk("rst_wrreq", rfifo_wrreq, 0);
    chk("rst_rdata", rfifo_data, 0);
    chk("rst_srd", sfifo_rdreq, 0);
    chk("rst_crd", cfifo_rdreq, 0);
    chk("rst_busy", busy, 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();

    // count mode, four cycles
    sq.push_back(mk(24'hA5A5A5, 0, 5'd4, 4, 24'h123456, 0, 0, 0));
    drain(200);
    chk("r025_rec", got[$], {1'b0, 5'd4, 24'h123456});
    chk("r025_mosi", mosi_ap, 24'hA5A5A5);

    // trigger hit on RUN cycle 3
    cq.push_back({8'h02, 24'h0000FF});
    cq.push_back({8'h03, 24'h000042});
    sq.push_back(mk(24'h111111, 1, 5'd10, 3, 24'hABCD42, 1, 24'h000000, 0));
    drain(200);
    chk("r026_rec", got[$], {1'b0, 5'd3, 24'hABCD42});

    // no match: timeout at the limit
    sq.push_back(mk(24'h222222, 1, 5'd10, 10, 24'h777700, 1, 24'h111111, 0));
    drain(200);
    chk("r027_tmo", got[$], {1'b1, 5'd10, 24'h777700});

    // match on the limit cycle wins
    sq.push_back(mk(24'h333333, 1, 5'd10, 10, 24'h555542, 1, 24'h111111, 0));
    drain(200);
    chk("r027_tie", got[$], {1'b0, 5'd10, 24'h555542});

    // zero cycles behaves as one, in both modes; 31 does not wrap
    sq.push_back(mk(24'h444444, 0, 5'd0, 1, 24'h0F0F0F, 0, 0, 0));
    drain(200);
    chk("cyc0_m0", got[$], {1'b0, 5'd1, 24'h0F0F0F});
    sq.push_back(mk(24'h555555, 1, 5'd0, 1, 24'h000001, 0, 0, 0));
    drain(200);
    chk("cyc0_m1", got[$], {1'b1, 5'd1, 24'h000001});
    sq.push_back(mk(24'h666666, 0, 5'd31, 31, 24'hFEDCBA, 0, 0, 0));
    drain(200);
    chk("cyc31", got[$], {1'b0, 5'd31, 24'hFEDCBA});

    // command before stimulus; unknown opcode ignored
    cq.push_back({8'h7F, 24'hFFFFFF});
    sq.push_back(mk(24'h3C3C3C, 1, 5'd2, 0, 0, 1, 24'h000042, 0));
    drain(200);
    chk("r029_order", obs_s[$] - obs_c[$], 1);
    chk("r029_rec", got[$], {1'b0, 5'd1, 24'h000042});

    // clock on mosi[0] and a 5-cycle full stall in WRITE
    cq.push_back({8'h01, 24'h000001});
    drain(50);
    lowcnt = 0;
    n0 = got.size();
    sq.push_back(mk(24'h00F00F, 0, 5'd2, 2, 24'h000002, 0, 0, 5));
    drain(200);
    chk("r028_rec", got[$], {1'b0, 5'd2, 24'h000002});
    chk("r028_nrec", got.size() - n0, 1);
    chk("r028_gated", lowcnt, 5);
    chk("r028_mosi", mosi_ap, 24'h00F00E);
    cq.push_back({8'h01, 24'h000000});
    drain(50);

    // back-to-back single-cycle vectors: one per 3 clocks
    for (int i = cyc; i < cyc + 40; i++) wf_tab[i] = 0;
    for (int i = 0; i < 4; i++)
      sq.push_back(mk(24'($urandom), 0, 5'd1, 0, 0, 0, 0, 0));
    drain(200);
    chk("r022_rate", obs_s[$] - obs_s[$-3], 9);

    // reset during RUN
    n0 = got.size();
    sq.push_back(mk(24'hDEAD01, 0, 5'd20, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10 && !busy; i++) step();
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("r030_mosi", mosi_data, 0);
    chk("r030_wrreq", rfifo_wrreq, 0);
    chk("r030_rdata", rfifo_data, 0);
    chk("r030_srd", sfifo_rdreq, 0);
    chk("r030_crd", cfifo_rdreq, 0);
    chk("r030_busy", busy, 0);
    model_reset();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (30) step();
    chk("r030_norec", got.size() - n0, 0);

    // randomized mix of commands and stimulus
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: cq.push_back({8'h01, 24'($urandom) & 24'h00000F});
          1: cq.push_back({8'h02, 24'($urandom & $urandom & $urandom)});
          2: cq.push_back({8'h03, 24'($urandom)});
          default: cq.push_back({8'h80 | 8'($urandom_range(0, 127)), 24'($urandom)});
        endcase
      end else begin
        sq.push_back(mk(24'($urandom), 1'($urandom),
                        ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 8)),
                        0, 0, 0, 0, 0));
      end
      repeat ($urandom_range(0, 4)) step();
    end
    drain(4000);
    finish_run();
  end

endmodule
